mem_responder: RTL

Memory-side responder for the multicycle core's fetch, load and store ports. It treats the core's per-stage strobes `pc_clk`, `load_clk` and `store_clk` as request pulses, sampled as data on the single system clock. It serialises all requests onto one single-port synchronous word RAM and returns instruction and load data on held output registers. It sits between the core and on-chip memory, and replaces the earlier direct-wired memory model.

---
 rtl/mem_responder_pkg.sv | 30 +++
 rtl/mem_responder_spram.sv | 35 +++
 rtl/mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module : mem_responder_pkg
// Brief  : Shared FSM, op and error-index definitions for mem_responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_ACC  = 2'd1,
        MEMR_RESP = 2'd2
    } memr_state_t;

    typedef enum logic [1:0] {
        MEMR_OP_FETCH = 2'd0,
        MEMR_OP_LOAD  = 2'd1,
        MEMR_OP_STORE = 2'd2
    } memr_op_t;

    localparam int unsigned MEMR_ERR_RANGE   = 0;
    localparam int unsigned MEMR_ERR_ALIGN   = 1;
    localparam int unsigned MEMR_ERR_OVERRUN = 2;

endpackage

`default_nettype wire

// File: rtl/mem_responder_spram.sv
// ============================================================================
// Module : spram
// Brief  : Single-port synchronous word RAM, registered read, no reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram
    import mem_responder_pkg::*;
#(
    parameter int W      = WORD_WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [W-1:0]      i_wdata,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : Serialises fetch/load/store strobe requests onto one word RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int W      = WORD_WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_clk,
    input  logic         pc_en,
    input  logic [W-1:0] pc,
    output logic [W-1:0] read_inst,
    input  logic         load_clk,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_clk,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         busy,
    output logic [2:0]   err
);

    logic r_pc_q, r_load_q, r_store_q;
    logic w_fetch_req, w_load_req, w_store_req;

    logic         r_pend_fetch, r_pend_load, r_pend_store;
    logic [W-1:0] r_fetch_addr, r_load_addr, r_store_addr, r_store_data;

    memr_state_t       r_state, w_state_nxt;
    memr_op_t          r_op, w_sel_op;
    logic [W-1:0]      w_sel_addr;
    logic              w_take_fetch, w_take_load, w_take_store;
    logic              w_sel_oor, w_sel_mis, w_start;
    logic [ADDR_W-1:0] r_word;
    logic [W-1:0]      r_wdata;
    logic              r_oor;

    logic [W-1:0] r_read_inst, r_l_data;
    logic [2:0]   r_err;

    logic         w_ram_we;
    logic [W-1:0] w_ram_rdata;

    // A request is a rising strobe edge qualified by its enable.
    assign w_fetch_req = pc_clk    & ~r_pc_q    & pc_en;
    assign w_load_req  = load_clk  & ~r_load_q  & load_en;
    assign w_store_req = store_clk & ~r_store_q & store_en;

    always_comb begin
        w_state_nxt  = r_state;
        w_take_fetch = 1'b0;
        w_take_load  = 1'b0;
        w_take_store = 1'b0;
        w_sel_op     = MEMR_OP_FETCH;
        w_sel_addr   = r_fetch_addr;
        case (r_state)
            MEMR_IDLE: begin
                if (r_pend_store) begin
                    w_take_store = 1'b1;
                    w_sel_op     = MEMR_OP_STORE;
                    w_sel_addr   = r_store_addr;
                    w_state_nxt  = MEMR_ACC;
                end else if (r_pend_load) begin
                    w_take_load  = 1'b1;
                    w_sel_op     = MEMR_OP_LOAD;
                    w_sel_addr   = r_load_addr;
                    w_state_nxt  = MEMR_ACC;
                end else if (r_pend_fetch) begin
                    w_take_fetch = 1'b1;
                    w_state_nxt  = MEMR_ACC;
                end
            end
            MEMR_ACC:  w_state_nxt = (r_op == MEMR_OP_STORE) ? MEMR_IDLE : MEMR_RESP;
            MEMR_RESP: w_state_nxt = MEMR_IDLE;
            default:   w_state_nxt = MEMR_IDLE;
        endcase
    end

    assign w_start   = (r_state == MEMR_IDLE) && (w_state_nxt == MEMR_ACC);
    assign w_sel_oor = |(w_sel_addr >> (ADDR_W + 2));
    assign w_sel_mis = |w_sel_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q       <= 1'b0;
            r_load_q     <= 1'b0;
            r_store_q    <= 1'b0;
            r_pend_fetch <= 1'b0;
            r_pend_load  <= 1'b0;
            r_pend_store <= 1'b0;
            r_fetch_addr <= '0;
            r_load_addr  <= '0;
            r_store_addr <= '0;
            r_store_data <= '0;
            r_state      <= MEMR_IDLE;
            r_op         <= MEMR_OP_FETCH;
            r_word       <= '0;
            r_wdata      <= '0;
            r_oor        <= 1'b0;
            r_read_inst  <= '0;
            r_l_data     <= '0;
            r_err        <= '0;
        end else begin
            r_pc_q    <= pc_clk;
            r_load_q  <= load_clk;
            r_store_q <= store_clk;

            // A slot being taken into service this edge is not lost by a new request.
            if (w_fetch_req) begin
                r_pend_fetch <= 1'b1;
                r_fetch_addr <= pc;
                if (r_pend_fetch && !w_take_fetch) r_err[MEMR_ERR_OVERRUN] <= 1'b1;
            end else if (w_take_fetch) begin
                r_pend_fetch <= 1'b0;
            end

            if (w_load_req) begin
                r_pend_load <= 1'b1;
                r_load_addr <= l_addr;
                if (r_pend_load && !w_take_load) r_err[MEMR_ERR_OVERRUN] <= 1'b1;
            end else if (w_take_load) begin
                r_pend_load <= 1'b0;
            end

            if (w_store_req) begin
                r_pend_store <= 1'b1;
                r_store_addr <= s_addr;
                r_store_data <= s_data;
                if (r_pend_store && !w_take_store) r_err[MEMR_ERR_OVERRUN] <= 1'b1;
            end else if (w_take_store) begin
                r_pend_store <= 1'b0;
            end

            r_state <= w_state_nxt;

            if (w_start) begin
                r_op    <= w_sel_op;
                r_word  <= w_sel_addr[ADDR_W+1:2];
                r_wdata <= r_store_data;
                r_oor   <= w_sel_oor;
                if (w_sel_oor) r_err[MEMR_ERR_RANGE] <= 1'b1;
                if (w_sel_mis) r_err[MEMR_ERR_ALIGN] <= 1'b1;
            end

            if (r_state == MEMR_RESP) begin
                if (r_op == MEMR_OP_FETCH) r_read_inst <= r_oor ? '0 : w_ram_rdata;
                if (r_op == MEMR_OP_LOAD)  r_l_data    <= r_oor ? '0 : w_ram_rdata;
            end
        end
    end

    // Reset gates the write so a store abandoned in ACC never reaches the RAM.
    assign w_ram_we = (r_state == MEMR_ACC) && (r_op == MEMR_OP_STORE) && !r_oor && !rst;

    spram #(
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_word),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign read_inst = r_read_inst;
    assign l_data    = r_l_data;
    assign err       = r_err;
    assign busy      = (r_state != MEMR_IDLE) | r_pend_fetch | r_pend_load | r_pend_store;

endmodule

`default_nettype wire
